// File: rtl/lsab_pkg.sv
// ============================================================================
//  Module   : lsab_pkg
//  Purpose  : Shared constants and types for the LSAB upstream buffer and drain.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsab_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    localparam int LSAB_RD_LATENCY     = 2;
    localparam int LSAB_SKID_DEPTH_DEF = 4;
    localparam int LSAB_FIFO_IDX_W     = 2;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [2:0]  ancill;
    } lsab_entry_t;

    localparam int LSAB_ENTRY_W = $bits(lsab_entry_t);

endpackage

`default_nettype wire

// File: rtl/lsab_skid.sv
// ============================================================================
//  Module   : lsab_skid
//  Purpose  : Synchronous FIFO holding drained words ahead of the consumer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsab_skid
    import lsab_pkg::*;
#(
    parameter int  DEPTH   = LSAB_SKID_DEPTH_DEF,
    parameter int  WIDTH   = LSAB_ENTRY_W,
    localparam int c_PTR_W = $clog2(DEPTH),
    localparam int c_OCC_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_din,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_dout,
    output logic [c_OCC_W-1:0] o_occ,
    output logic               o_empty,
    output logic               o_full
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_occ;
    logic               w_push_ok;
    logic               w_pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign o_empty   = (r_occ == '0);
    assign o_full    = (r_occ == c_OCC_W'(DEPTH));
    assign o_occ     = r_occ;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= f_inc(r_rd_ptr);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_occ <= r_occ + c_OCC_W'(1);
                2'b01:   r_occ <= r_occ - c_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

`default_nettype wire

// File: rtl/lsab_drain.sv
// ============================================================================
//  Module   : lsab_drain
//  Purpose  : Drains one transfer from an LSAB upstream buffer into a credit-
//             controlled output FIFO, ending at packet end or the word cap.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsab_drain
    import lsab_pkg::*;
#(
    parameter logic [LSAB_FIFO_IDX_W-1:0] FIFO_SEL   = 2'h0,
    parameter int                         SKID_DEPTH = LSAB_SKID_DEPTH_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic [7:0]                 MAX_LEN,
    input  logic                       STOP,
    input  logic                       INT_IN,
    input  logic [2:0]                 ANCILL_IN,
    input  logic [31:0]                DATA_IN,
    output logic                       READ,
    output logic [LSAB_FIFO_IDX_W-1:0] READ_FIFO,
    output logic [31:0]                DOUT,
    output logic                       DOUT_VALID,
    input  logic                       DOUT_READY,
    output logic                       DOUT_LAST,
    output logic [2:0]                 DOUT_ANCILL,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       END_BY_INT
);

    localparam int c_L     = LSAB_RD_LATENCY;
    localparam int c_OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int c_CRD_W = c_OCC_W + 1;

    logic [1:0]         r_state;
    logic [8:0]         r_cap;
    logic [8:0]         r_cnt;
    logic [c_L-1:0]     r_if_v;
    logic [c_L-1:0]     r_if_last;
    logic               r_ended;
    logic               r_end_by_int;

    logic [c_OCC_W-1:0] w_occ;
    logic               w_empty;
    logic               w_full;
    lsab_entry_t        w_head;
    lsab_entry_t        w_push_ent;
    logic [c_CRD_W-1:0] w_inflight;
    logic               w_read;
    logic               w_issue_last;
    logic               w_capture;
    logic               w_drop;
    logic               w_pkt_end;
    logic               w_pop;
    logic               w_done;
    logic [c_L-1:0]     w_if_next;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < c_L; i++) begin
            w_inflight = w_inflight + c_CRD_W'(r_if_v[i]);
        end
    end

    // Reads in flight reserve a FIFO slot, so back-pressure can never overflow it.
    assign w_read       = (r_state == c_ST_RUN) && !STOP &&
                          ((c_CRD_W'(w_occ) + w_inflight) < c_CRD_W'(SKID_DEPTH));
    assign w_issue_last = w_read && ((r_cnt + 9'd1) == r_cap);
    assign w_if_next    = {r_if_v[c_L-2:0], w_read};

    assign w_capture = r_if_v[c_L-1] && !r_ended;
    assign w_drop    = r_if_v[c_L-1] && r_ended;
    assign w_pkt_end = w_capture && INT_IN;

    always_comb begin
        w_push_ent.data   = DATA_IN;
        w_push_ent.last   = w_pkt_end || r_if_last[c_L-1];
        w_push_ent.ancill = w_pkt_end ? ANCILL_IN : 3'b000;
    end

    lsab_skid #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (LSAB_ENTRY_W)
    ) u_skid (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_capture),
        .i_din   (w_push_ent),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_occ   (w_occ),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign w_pop  = !w_empty && DOUT_READY;
    // The last-flagged entry is always the final one, so popping it empties the FIFO.
    assign w_done = (r_state != c_ST_IDLE) && w_pop && w_head.last;

    assign READ        = w_read;
    assign READ_FIFO   = FIFO_SEL;
    assign DOUT_VALID  = !w_empty;
    assign DOUT        = w_empty ? 32'd0 : w_head.data;
    assign DOUT_LAST   = !w_empty && w_head.last;
    assign DOUT_ANCILL = w_empty ? 3'b000 : w_head.ancill;
    assign BUSY        = (r_state != c_ST_IDLE);
    assign DONE        = w_done;
    assign END_BY_INT  = w_done && r_end_by_int;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= c_ST_IDLE;
            r_cap        <= '0;
            r_cnt        <= '0;
            r_if_v       <= '0;
            r_if_last    <= '0;
            r_ended      <= 1'b0;
            r_end_by_int <= 1'b0;
        end else begin
            r_if_v    <= w_if_next;
            r_if_last <= {r_if_last[c_L-2:0], w_issue_last};
            if (w_read)    r_cnt        <= r_cnt + 9'd1;
            if (w_pkt_end) r_end_by_int <= 1'b1;
            if (w_capture && w_push_ent.last) r_ended <= 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    if (START) begin
                        r_state      <= c_ST_RUN;
                        r_cap        <= (MAX_LEN == 8'd0) ? 9'd256 : {1'b0, MAX_LEN};
                        r_cnt        <= '0;
                        r_ended      <= 1'b0;
                        r_end_by_int <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    if (w_issue_last || w_pkt_end) r_state <= c_ST_FLUSH;
                end
                c_ST_FLUSH: begin
                    if (w_done)                r_state <= c_ST_IDLE;
                    else if (w_if_next == '0)  r_state <= c_ST_DRAIN;
                end
                c_ST_DRAIN: begin
                    if (w_done) r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    a_no_word_after_end: assert property (@(posedge CLK) disable iff (RST) !w_drop);
    a_no_overflow:       assert property (@(posedge CLK) disable iff (RST) !(w_capture && w_full));

endmodule

`default_nettype wire
